// File: rtl/ml_enc_64to6_pkg.sv
// Shared constants and state encoding for the 64-row match-line encoder.
package ml_enc_64to6_pkg;

  localparam int ML_ROWS   = 64;
  localparam int ML_ADDR_W = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } ml_state_e;

  localparam bit SCAN_LO_FIRST = 1'b0;
  localparam bit SCAN_HI_FIRST = 1'b1;

endpackage

// File: rtl/ml_enc_64to6_prio_enc_8to3.sv
// 8-to-3 priority encoder with selectable direction; the inverse of the 3-to-8 row decoder.
module prio_enc_8to3 (
  input  logic [7:0] req,
  input  logic       hi_first,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = 3'd0;
    if (hi_first) begin
      for (int i = 0; i < 8; i++) begin
        if (req[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (req[i]) idx = 3'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ml_enc_64to6.sv
// Match-line encoder: captures an active-low 64-bit hit vector and streams
// the row address of every hit, one per handshake, in priority order.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | no pending hits; waiting for load
//   ST_SCAN | pend non-zero; hit_addr/hit_last presented
module ml_enc_64to6
  import ml_enc_64to6_pkg::*;
#(
  parameter int ADDR_W   = ML_ADDR_W,
  parameter bit SCAN_DIR = SCAN_LO_FIRST
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [(1<<ADDR_W)-1:0] match_n,
  input  logic                   load,
  input  logic                   abort,
  output logic                   busy,
  output logic                   hit_valid,
  input  logic                   hit_ready,
  output logic [ADDR_W-1:0]      hit_addr,
  output logic                   hit_last,
  output logic [ADDR_W:0]        hit_count,
  output logic                   multi_hit,
  output logic                   no_hit
);

  localparam int ROWS = 1 << ADDR_W;
  localparam logic [ROWS-1:0] ONE = 1;

  ml_state_e          state;
  logic [ROWS-1:0]    pend;
  logic [ROWS-1:0]    cap;
  logic [ADDR_W:0]    cap_cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  enc_addr;
  logic [7:0]         grp_any;
  logic [2:0]         grp_idx;
  logic [2:0]         off_idx;
  logic [7:0]         grp_bits;
  logic               any_grp;
  logic               any_off;
  logic               pend_single;
  logic               hs;
  logic               load_acc;
  logic               hi_first;

  assign hi_first = (SCAN_DIR == SCAN_HI_FIRST);
  assign cap      = ~match_n;

  always_comb begin
    cap_cnt = '0;
    for (int i = 0; i < ROWS; i++) begin
      cap_cnt = cap_cnt + (ADDR_W+1)'(cap[i]);
    end
  end

  always_comb begin
    grp_any = '0;
    for (int g = 0; g < 8; g++) begin
      grp_any[g] = |pend[g*8 +: 8];
    end
  end

  // Two-level encode: pick the winning group of 8, then the winning bit inside it.
  prio_enc_8to3 u_enc_grp (
    .req      (grp_any),
    .hi_first (hi_first),
    .idx      (grp_idx),
    .any      (any_grp)
  );

  assign grp_bits = pend[{grp_idx, 3'b000} +: 8];

  prio_enc_8to3 u_enc_off (
    .req      (grp_bits),
    .hi_first (hi_first),
    .idx      (off_idx),
    .any      (any_off)
  );

  assign enc_addr    = {grp_idx, off_idx};
  assign pend_single = any_grp & any_off & ((pend & (pend - ONE)) == '0);

  assign busy      = (state == ST_SCAN);
  assign hit_valid = busy;
  assign hit_last  = busy & pend_single;
  assign hit_addr  = busy ? enc_addr : addr_q;

  assign hs       = hit_valid & hit_ready;
  assign load_acc = load & ~abort & (~busy | (hs & hit_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pend      <= '0;
      addr_q    <= '0;
      hit_count <= '0;
      multi_hit <= 1'b0;
      no_hit    <= 1'b0;
    end else begin
      no_hit <= 1'b0;
      if (busy) addr_q <= enc_addr;

      if (abort) begin
        pend  <= '0;
        state <= ST_IDLE;
      end else if (load_acc) begin
        pend      <= cap;
        hit_count <= cap_cnt;
        multi_hit <= (cap_cnt >= (ADDR_W+1)'(2));
        if (cap != '0) begin
          state <= ST_SCAN;
        end else begin
          state  <= ST_IDLE;
          no_hit <= 1'b1;
        end
      end else if (hs) begin
        pend <= pend & ~(ONE << enc_addr);
        if (hit_last) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ml_enc_64to6.sv
// Directed bench for ml_enc_64to6: one low-first and one high-first instance
// driven from the same stimulus.
module tb_ml_enc_64to6;

  logic        clk;
  logic        rst_n;
  logic [63:0] match_n;
  logic        load;
  logic        abort;
  logic        hit_ready;

  logic        busy, hit_valid, hit_last, multi_hit, no_hit;
  logic [5:0]  hit_addr;
  logic [6:0]  hit_count;

  logic        busy_h, hit_valid_h, hit_last_h, multi_hit_h, no_hit_h;
  logic [5:0]  hit_addr_h;
  logic [6:0]  hit_count_h;

  int n_chk;
  int n_err;

  ml_enc_64to6 #(.ADDR_W(6), .SCAN_DIR(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .match_n   (match_n),
    .load      (load),
    .abort     (abort),
    .busy      (busy),
    .hit_valid (hit_valid),
    .hit_ready (hit_ready),
    .hit_addr  (hit_addr),
    .hit_last  (hit_last),
    .hit_count (hit_count),
    .multi_hit (multi_hit),
    .no_hit    (no_hit)
  );

  ml_enc_64to6 #(.ADDR_W(6), .SCAN_DIR(1'b1)) dut_hi (
    .clk       (clk),
    .rst_n     (rst_n),
    .match_n   (match_n),
    .load      (load),
    .abort     (abort),
    .busy      (busy_h),
    .hit_valid (hit_valid_h),
    .hit_ready (hit_ready),
    .hit_addr  (hit_addr_h),
    .hit_last  (hit_last_h),
    .hit_count (hit_count_h),
    .multi_hit (multi_hit_h),
    .no_hit    (no_hit_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int lo_seq [3] = '{0, 5, 63};
  int hi_seq [3] = '{63, 5, 0};

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    match_n   = '1;
    load      = 1'b0;
    abort     = 1'b0;
    hit_ready = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_valid", hit_valid, 0);
    chk("rst_addr",  hit_addr, 0);
    chk("rst_last",  hit_last, 0);
    chk("rst_count", hit_count, 0);
    chk("rst_multi", multi_hit, 0);
    chk("rst_nohit", no_hit, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", hit_valid, 0);

    // single hit at row 37
    match_n = ~(64'd1 << 37);
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk("s_valid", hit_valid, 1);
    chk("s_addr",  hit_addr, 37);
    chk("s_last",  hit_last, 1);
    chk("s_count", hit_count, 1);
    chk("s_multi", multi_hit, 0);
    chk("s_addr_hi", hit_addr_h, 37);
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    chk("s_busy_after", busy, 0);

    // rows 0, 5, 63 with backpressure
    match_n = ~((64'd1 << 0) | (64'd1 << 5) | (64'd1 << 63));
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk("m_count", hit_count, 3);
    chk("m_multi", multi_hit, 1);
    for (int b = 0; b < 3; b++) begin
      chk("m_valid",   hit_valid, 1);
      chk("m_addr",    hit_addr, 64'(lo_seq[b]));
      chk("m_addr_hi", hit_addr_h, 64'(hi_seq[b]));
      chk("m_last",    hit_last, (b == 2) ? 1 : 0);
      chk("m_last_hi", hit_last_h, (b == 2) ? 1 : 0);
      hit_ready = 1'b0;
      tick();
      chk("m_stall_addr",    hit_addr, 64'(lo_seq[b]));
      chk("m_stall_addr_hi", hit_addr_h, 64'(hi_seq[b]));
      chk("m_stall_last",    hit_last, (b == 2) ? 1 : 0);
      hit_ready = 1'b1;
      tick();
    end
    hit_ready = 1'b0;
    chk("m_busy_end", busy, 0);
    chk("m_busy_end_hi", busy_h, 0);

    // empty vector
    match_n = '1;
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk("e_nohit", no_hit, 1);
    chk("e_busy",  busy, 0);
    chk("e_count", hit_count, 0);
    chk("e_multi", multi_hit, 0);
    tick();
    chk("e_nohit_pulse", no_hit, 0);
    chk("e_busy2", busy, 0);

    // full vector drains in 64 consecutive beats
    match_n   = '0;
    load      = 1'b1;
    hit_ready = 1'b1;
    tick();
    load = 1'b0;
    chk("f_count", hit_count, 64);
    chk("f_multi", multi_hit, 1);
    for (int i = 0; i < 64; i++) begin
      chk("f_valid", hit_valid, 1);
      chk("f_addr",  hit_addr, 64'(i));
      chk("f_last",  hit_last, (i == 63) ? 1 : 0);
      tick();
    end
    hit_ready = 1'b0;
    chk("f_busy_end", busy, 0);
    chk("f_count_hold", hit_count, 64);
    chk("f_addr_hold", hit_addr, 63);

    // back-to-back: load {12} on the last handshake of {3}
    match_n = ~(64'd1 << 3);
    load    = 1'b1;
    tick();
    chk("b_addr3", hit_addr, 3);
    chk("b_last3", hit_last, 1);
    match_n   = ~(64'd1 << 12);
    load      = 1'b1;
    hit_ready = 1'b1;
    tick();
    load      = 1'b0;
    hit_ready = 1'b0;
    chk("b_valid", hit_valid, 1);
    chk("b_addr",  hit_addr, 12);
    chk("b_last",  hit_last, 1);
    chk("b_count", hit_count, 1);
    hit_ready = 1'b1;
    tick();
    hit_ready = 1'b0;
    chk("b_busy_end", busy, 0);

    // load while busy and not on the last beat is ignored
    match_n = ~((64'd1 << 20) | (64'd1 << 30));
    load    = 1'b1;
    tick();
    match_n = ~(64'd1 << 50);
    tick();
    load = 1'b0;
    chk("i_addr",  hit_addr, 20);
    chk("i_count", hit_count, 2);
    hit_ready = 1'b1;
    tick();
    chk("i_addr2", hit_addr, 30);
    tick();
    hit_ready = 1'b0;
    chk("i_busy_end", busy, 0);

    // abort during beat 2 of {1, 2, 9}, with load and ready also high
    match_n = ~((64'd1 << 1) | (64'd1 << 2) | (64'd1 << 9));
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk("a_addr1", hit_addr, 1);
    hit_ready = 1'b1;
    tick();
    chk("a_addr2", hit_addr, 2);
    abort   = 1'b1;
    load    = 1'b1;
    match_n = ~(64'd1 << 40);
    tick();
    abort     = 1'b0;
    load      = 1'b0;
    hit_ready = 1'b0;
    chk("a_valid",  hit_valid, 0);
    chk("a_count",  hit_count, 3);
    chk("a_multi",  multi_hit, 1);
    chk("a_addr_hold", hit_addr, 2);
    tick();
    chk("a_valid2", hit_valid, 0);

    // asynchronous reset mid-scan
    match_n = '0;
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk("r_valid_pre", hit_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_busy",  busy, 0);
    chk("r_valid", hit_valid, 0);
    chk("r_addr",  hit_addr, 0);
    chk("r_count", hit_count, 0);
    chk("r_multi", multi_hit, 0);
    chk("r_last",  hit_last, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    hit_ready = 1'b1;
    tick();
    tick();
    chk("r_valid_post", hit_valid, 0);
    chk("r_valid_post_hi", hit_valid_h, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ml_enc_64to6.md
Name: ml_enc_64to6

Overview:
Match-line encoder for the 64-row array; it is the inverse path of the 6-to-64 wordline decoder. It captures a 64-bit active-low match/hit vector in one cycle, then streams the 6-bit row address of every asserted line, one per handshake, in priority order. It sits between the array sense/match outputs and the row-address consumer (controller, CAM result logic, BIST).

Parameters:
ADDR_W, 6, row-address width; only 6 is supported (64 rows); the row count is a localparam, 1 << ADDR_W.
SCAN_DIR, 0, priority order: 0 = lowest index first, 1 = highest index first.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
match_n  input  64  match lines, active-low, same polarity as the wordlines; bit i = row i.
load  input  1  capture request for match_n.
abort  input  1  discards the current scan.
busy  output  1  scan in progress (state SCAN).
hit_valid  output  1  hit_addr is valid.
hit_ready  input  1  consumer accepts hit_addr.
hit_addr  output  6  encoded row address.
hit_last  output  1  current beat is the final pending hit.
hit_count  output  7  number of hits in the captured vector, 0..64.
multi_hit  output  1  captured vector had 2 or more hits.
no_hit  output  1  one-cycle pulse: the captured vector had zero hits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state IDLE; pend = 0.
  - busy, hit_valid, hit_last, no_hit, multi_hit = 0; hit_addr = 0; hit_count = 0.
- States: IDLE, SCAN.
  - busy = (state == SCAN).
  - hit_valid = busy.
- Capture rule: load_acc = load & !abort & (!busy | (hit_valid & hit_ready & hit_last)).
- On load_acc at edge N:
  - pend <= ~match_n.
  - hit_count <= popcount(~match_n).
  - multi_hit <= (popcount >= 2).
  - If ~match_n != 0, state <= SCAN, so hit_valid is 1 from cycle N+1 (latency 1).
  - Otherwise state stays IDLE and no_hit = 1 for exactly cycle N+1.
- load while busy is ignored, except when it coincides with the last handshake.
- SCAN outputs:
  - hit_addr = priority encode of pend (lowest set bit if SCAN_DIR=0, highest if SCAN_DIR=1). It is combinational from registered pend, so there is no comb path from match_n.
  - hit_last = (pend has exactly one bit set).
- Handshake: on hit_valid & hit_ready, the bit at hit_addr is cleared in pend.
  - If hit_last, state <= IDLE, unless load_acc is true in the same cycle; a new capture then overrides and the scan continues with no bubble.
- Backpressure: while hit_valid & !hit_ready, hit_addr, hit_last and pend hold stable.
- Throughput: 1 address per cycle under continuous hit_ready; a 64-hit vector drains in 64 cycles.
- hit_count and multi_hit hold until the next load_acc; abort does not clear them.
- abort (any state):
  - pend <= 0, state <= IDLE, so hit_valid = 0 the next cycle.
  - abort has priority over load and over a handshake in the same cycle; that handshake is not consumed.
- hit_addr when idle: holds its last value; consumers must qualify it with hit_valid.
- Reset asserted mid-scan: all state clears immediately; no partial beats are produced after deassertion.

Decomposition:
- Shared package holds:
  - ML_ROWS = 64 and ML_ADDR_W = 6.
  - State encoding: ST_IDLE = 1'b0, ST_SCAN = 1'b1.
  - Scan-direction constants: SCAN_LO_FIRST = 0, SCAN_HI_FIRST = 1.
- One natural sub-module, prio_enc_8to3 (8-bit one-hot-any priority encoder with direction input, plus an any-bit output), mirroring the 3-to-8 decoder:
  - One instance computes the group index over the 8 group-OR bits.
  - A second instance encodes the selected 8-bit group.
  - hit_addr = {group, offset}.
- Popcount and the last-bit test (pend & (pend - 1)) == 0 stay in the top level.

Test Plan:
- Reset: assert rst_n low mid-scan with hit_valid = 1 -> all outputs 0 asynchronously; after release, hit_valid stays 0 until the next load.
- Single hit: match_n = ~(1 << 37), load -> next cycle hit_valid = 1, hit_addr = 37, hit_last = 1, hit_count = 1, multi_hit = 0; after the handshake, busy = 0.
- Multi-hit with backpressure: hits at rows 0, 5, 63, hit_ready toggling 0/1 -> beats 0, 5, 63 (SCAN_DIR=1: 63, 5, 0), stable while stalled, hit_last only on the third beat, hit_count = 3.
- Empty and full vectors:
  - match_n = all ones -> no_hit pulses one cycle, busy stays 0, hit_count = 0.
  - match_n = all zeros, hit_ready = 1 -> 64 consecutive beats 0..63, hit_last on beat 63, hit_count = 64.
- Back-to-back: load of {12} asserted in the same cycle as the last handshake of the previous {3} scan -> the next cycle shows hit_addr = 12 with no idle bubble.
- Abort: abort during beat 2 of {1, 2, 9}, with hit_ready = 1 and load = 1 in the same cycle -> hit_valid = 0 the next cycle, load ignored, hit_count still 3.
